// File: rtl/branch_pred_pkg.sv
// Shared encodings and field widths for the fetch-side branch predictor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_pred_pkg;

    localparam int PC_W   = 32;
    localparam int CTR_W  = 2;

    localparam logic [PC_W-1:0] PC_INCREMENT = 32'd4;

    localparam logic [CTR_W-1:0] CTR_SNT = 2'b00;
    localparam logic [CTR_W-1:0] CTR_WNT = 2'b01;
    localparam logic [CTR_W-1:0] CTR_WT  = 2'b10;
    localparam logic [CTR_W-1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/saturating_counter_2bit.sv
// Next-state function of a 2-bit saturating direction counter.
// Latency: combinational.
// Backpressure: none.
module saturating_counter_2bit
    import branch_pred_pkg::*;
(
    input  logic [CTR_W-1:0] ctr,
    input  logic             taken,
    output logic [CTR_W-1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_prediction_unit.sv
// Direct-mapped tagged 2-bit-counter predictor with EX-side update, mispredict redirect and statistics.
// Latency: lookup and mispredict are combinational; table/counter updates visible the cycle after.
// Backpressure: none; one update per cycle accepted whenever Update_Valid is high.
module branch_prediction_unit
    import branch_pred_pkg::*;
#(
    parameter int               INDEX_BITS = 6,
    parameter int               TAG_BITS   = 8,
    parameter logic [CTR_W-1:0] CTR_INIT   = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] Fetch_PC,
    output logic            Predict_Taken,
    output logic [PC_W-1:0] Predicted_Target,
    input  logic            Update_Valid,
    input  logic [PC_W-1:0] Update_PC,
    input  logic            Update_Taken,
    input  logic [PC_W-1:0] Update_Target,
    input  logic            Update_Pred_Taken,
    input  logic [PC_W-1:0] Update_Pred_Target,
    output logic            Mispredict,
    output logic [PC_W-1:0] Redirect_PC,
    output logic [PC_W-1:0] Branch_Count,
    output logic [PC_W-1:0] Mispredict_Count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LSB = INDEX_BITS + 2;

    logic                  valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]       target_q [ENTRIES];
    logic [CTR_W-1:0]      ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] f_idx, u_idx;
    logic [TAG_BITS-1:0]   f_tag, u_tag;
    logic                  f_hit, u_hit;
    logic [CTR_W-1:0]      u_ctr_next;

    assign f_idx = Fetch_PC[INDEX_BITS+1:2];
    assign f_tag = Fetch_PC[TAG_LSB +: TAG_BITS];
    assign u_idx = Update_PC[INDEX_BITS+1:2];
    assign u_tag = Update_PC[TAG_LSB +: TAG_BITS];

    // Low PC bits and bits above the tag never take part in indexing or matching.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{Fetch_PC[1:0], Fetch_PC[PC_W-1:TAG_LSB+TAG_BITS],
                              Update_PC[1:0], Update_PC[PC_W-1:TAG_LSB+TAG_BITS]};

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign Predict_Taken    = f_hit && ctr_q[f_idx][CTR_W-1];
    assign Predicted_Target = Predict_Taken ? target_q[f_idx] : Fetch_PC + PC_INCREMENT;

    assign Mispredict  = Update_Valid &&
                         ((Update_Taken != Update_Pred_Taken) ||
                          (Update_Taken && (Update_Target != Update_Pred_Target)));
    assign Redirect_PC = Update_Taken ? Update_Target : Update_PC + PC_INCREMENT;

    saturating_counter_2bit u_sat_ctr (
        .ctr      (ctr_q[u_idx]),
        .taken    (Update_Taken),
        .ctr_next (u_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else if (Update_Valid) begin
            if (u_hit) begin
                ctr_q[u_idx] <= u_ctr_next;
                if (Update_Taken) target_q[u_idx] <= Update_Target;
            end else if (Update_Taken) begin
                // A taken miss evicts whatever aliased into this slot.
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= Update_Target;
                ctr_q[u_idx]    <= CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Branch_Count     <= '0;
            Mispredict_Count <= '0;
        end else begin
            if (Update_Valid && (Branch_Count != '1))
                Branch_Count <= Branch_Count + 32'd1;
            if (Mispredict && (Mispredict_Count != '1))
                Mispredict_Count <= Mispredict_Count + 32'd1;
        end
    end

endmodule
